// File: rtl/serial_word_receiver.sv
// Deserializes a sync-framed serial bitstream into WIDTH-bit words behind a valid/ready holding register.
// Define SERIAL_RX_PARITY_EN to add a trailing even-parity bit per frame and the parity_err pulse.
module serial_word_receiver #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_en,
   input  logic             sync,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun,
`ifdef SERIAL_RX_PARITY_EN
   output logic             parity_err,
`endif
   input  logic             clr_overrun
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RECV
`ifdef SERIAL_RX_PARITY_EN
      , PARITY
`endif
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] word;
   logic             complete;
   logic             accept;
   logic             drop;

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] base, input logic b);
      if (MSB_FIRST)
         return {base[WIDTH-2:0], b};
      else
         return {b, base[WIDTH-1:1]};
   endfunction

   // A word completes on its last data bit, or on a matching parity bit when parity is enabled
   always_comb begin
      shifted  = shift_in(shreg, din);
      word     = shifted;
      complete = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      word     = shreg;
      complete = din_en && !sync && (state == PARITY) && ((^shreg) == din);
`else
      complete = din_en && !sync && (state == RECV) && (count == LAST_BIT);
`endif
   end

   assign accept = complete && (!dout_valid || dout_ready);
   assign drop   = complete && dout_valid && !dout_ready;
   assign busy   = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         shreg      <= '0;
         count      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         if (accept) begin
            dout       <= word;
            dout_valid <= 1'b1;
         end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
         end

         // A fresh drop outranks a clear requested on the same edge
         if (drop)
            overrun <= 1'b1;
         else if (clr_overrun)
            overrun <= 1'b0;

         if (din_en) begin
            case (state)
               IDLE: begin
                  if (sync) begin
                     shreg <= shift_in('0, din);
                     count <= CW'(1);
                     state <= RECV;
                  end
               end
               RECV: begin
                  if (sync) begin
                     shreg     <= shift_in('0, din);
                     count     <= CW'(1);
                     frame_err <= 1'b1;
                  end else begin
                     shreg <= shifted;
                     count <= count + CW'(1);
                     if (count == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= IDLE;
`endif
                     end
                  end
               end
`ifdef SERIAL_RX_PARITY_EN
               PARITY: begin
                  if (sync) begin
                     shreg     <= shift_in('0, din);
                     count     <= CW'(1);
                     frame_err <= 1'b1;
                     state     <= RECV;
                  end else begin
                     state <= IDLE;
                     if ((^shreg) != din)
                        parity_err <= 1'b1;
                  end
               end
`endif
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Scoreboard bench for serial_word_receiver (WIDTH=4, MSB first); expected words queue up as frames are sent.
module tb_serial_word_receiver;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst;
   logic             din;
   logic             din_en;
   logic             sync;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic             busy;
   logic             frame_err;
   logic             overrun;
   logic             clr_overrun;
`ifdef SERIAL_RX_PARITY_EN
   logic             parity_err;
`endif

   int               numCompared;
   int               numMismatched;
   logic [WIDTH-1:0] sbQueue[$];

   serial_word_receiver #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .din_en      (din_en),
      .sync        (sync),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .dout_ready  (dout_ready),
      .busy        (busy),
      .frame_err   (frame_err),
      .overrun     (overrun),
`ifdef SERIAL_RX_PARITY_EN
      .parity_err  (parity_err),
`endif
      .clr_overrun (clr_overrun)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      numCompared++;
      if (observed !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // One clock with the given inputs; returns just after the edge that consumed them
   task automatic applyStimulus(input logic en, input logic b, input logic s);
      din_en = en;
      din    = b;
      sync   = s;
      @(posedge clk);
      #1;
      din_en = 1'b0;
      sync   = 1'b0;
   endtask

   task automatic sendWord(input logic [WIDTH-1:0] word, input bit gap, input bit expectLoad);
      if (expectLoad)
         sbQueue.push_back(word);
      for (int i = WIDTH - 1; i >= 0; i--) begin
         applyStimulus(1'b1, word[i], (i == WIDTH - 1));
         if (gap && i > 0) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput("busy_gap", {31'd0, busy}, 32'd1);
         end
      end
`ifdef SERIAL_RX_PARITY_EN
      applyStimulus(1'b1, ^word, 1'b0);
`endif
   endtask

   // Every handshake the consumer performs must match the oldest queued word
   always @(negedge clk) begin
      if (!rst && dout_valid && dout_ready) begin
         if (sbQueue.size() == 0)
            checkOutput("sb_underflow", sbQueue.size(), 32'd1);
         else
            checkOutput("sb_word", {28'd0, dout}, {28'd0, sbQueue.pop_front()});
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      numCompared   = 0;
      numMismatched = 0;
      clk           = 1'b0;
      rst           = 1'b1;
      din           = 1'b0;
      din_en        = 1'b0;
      sync          = 1'b0;
      dout_ready    = 1'b1;
      clr_overrun   = 1'b0;
      repeat (2) applyStimulus(1'b1, 1'b1, 1'b1);
      rst = 1'b0;

      checkOutput("rst_dout", {28'd0, dout}, 32'd0);
      checkOutput("rst_valid", {31'd0, dout_valid}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);

      $display("[TB] unsynced and disabled bits are ignored in IDLE");
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("idle_ignore_busy", {31'd0, busy}, 32'd0);

      $display("[TB] basic frame 1011");
      sendWord(4'b1011, 1'b0, 1'b1);
      checkOutput("basic_valid", {31'd0, dout_valid}, 32'd1);
      checkOutput("basic_dout", {28'd0, dout}, 32'hB);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("basic_valid_drop", {31'd0, dout_valid}, 32'd0);

      $display("[TB] frame 1011 with enable gaps");
      sendWord(4'b1011, 1'b1, 1'b1);
      checkOutput("gap_valid", {31'd0, dout_valid}, 32'd1);
      checkOutput("gap_dout", {28'd0, dout}, 32'hB);
      checkOutput("gap_busy_done", {31'd0, busy}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);

      $display("[TB] stalled consumer: A held, 5 dropped");
      dout_ready = 1'b0;
      sendWord(4'hA, 1'b0, 1'b1);
      checkOutput("stall_overrun_pre", {31'd0, overrun}, 32'd0);
      sendWord(4'h5, 1'b0, 1'b0);
      checkOutput("stall_overrun", {31'd0, overrun}, 32'd1);
      checkOutput("stall_valid", {31'd0, dout_valid}, 32'd1);
      checkOutput("stall_dout", {28'd0, dout}, 32'hA);
      clr_overrun = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      clr_overrun = 1'b0;
      checkOutput("clr_overrun", {31'd0, overrun}, 32'd0);
      checkOutput("clr_dout", {28'd0, dout}, 32'hA);
      dout_ready = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("stall_drain", {31'd0, dout_valid}, 32'd0);

      $display("[TB] back-to-back 3 then C");
      sendWord(4'h3, 1'b0, 1'b1);
      checkOutput("b2b_first", {28'd0, dout}, 32'h3);
      sendWord(4'hC, 1'b0, 1'b1);
      checkOutput("b2b_second", {28'd0, dout}, 32'hC);
      checkOutput("b2b_overrun", {31'd0, overrun}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);

      $display("[TB] early sync aborts frame");
      applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("abort_no_err_yet", {31'd0, frame_err}, 32'd0);
      sbQueue.push_back(4'b1100);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("abort_frame_err", {31'd0, frame_err}, 32'd1);
      checkOutput("abort_busy", {31'd0, busy}, 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("abort_err_pulse", {31'd0, frame_err}, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
`ifdef SERIAL_RX_PARITY_EN
      applyStimulus(1'b1, 1'b0, 1'b0);
`endif
      checkOutput("abort_valid", {31'd0, dout_valid}, 32'd1);
      checkOutput("abort_dout", {28'd0, dout}, 32'hC);
      applyStimulus(1'b0, 1'b0, 1'b0);

      $display("[TB] reset mid-frame");
      applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("midrst_busy_pre", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0);
      rst = 1'b0;
      checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
      checkOutput("midrst_dout", {28'd0, dout}, 32'd0);
      checkOutput("midrst_valid", {31'd0, dout_valid}, 32'd0);
      checkOutput("midrst_frame_err", {31'd0, frame_err}, 32'd0);
      sendWord(4'h9, 1'b0, 1'b1);
      checkOutput("midrst_next_dout", {28'd0, dout}, 32'h9);
      applyStimulus(1'b0, 1'b0, 1'b0);

`ifdef SERIAL_RX_PARITY_EN
      $display("[TB] bad parity discards word");
      applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("par_err", {31'd0, parity_err}, 32'd1);
      checkOutput("par_valid", {31'd0, dout_valid}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("par_err_pulse", {31'd0, parity_err}, 32'd0);
`endif

      checkOutput("sb_empty", sbQueue.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Downstream stage of the 4-bit parallel-in/serial-out shifter: deserializes its MSB-first serial bitstream back into parallel words.
- Frames words with a sync strobe, counts bits, and presents each completed word on a registered output with a valid/ready handshake.
- A one-word holding register absorbs consumer stalls. A sticky overrun flag reports words dropped because the consumer did not take the previous word.

Parameters:
- WIDTH, 4, data bits per word (2..32).
- MSB_FIRST, 1, 1: first received bit lands in dout[WIDTH-1]. 0: first bit lands in dout[0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data bit.
- din_en  input  1  din is sampled on this clock edge only when din_en=1.
- sync  input  1  qualified by din_en; marks the current bit as the first bit of a word.
- dout  output  WIDTH  received word (holding register).
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid&&dout_ready.
- busy  output  1  a frame is in progress (state RECV).
- frame_err  output  1  one-cycle pulse: frame aborted by an early sync.
- overrun  output  1  sticky: a completed word was dropped.
- clr_overrun  input  1  clears overrun (ignored while rst=1).

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; shift register and bit counter cleared.
  - dout=0, dout_valid=0, busy=0, frame_err=0, overrun=0.
  - Any partial frame is discarded. Reset has priority over all other inputs.
- Edges with din_en=0 change nothing except the handshake and clr_overrun. din and sync are ignored.
- State IDLE:
  - din_en&&sync: capture din as bit 0 of the frame, set count=1, go to RECV.
  - din_en&&!sync: bit is discarded; remain in IDLE.
- State RECV:
  - din_en&&!sync: shift din in and increment count.
  - When the captured bit is bit WIDTH-1, the word is complete. Return to IDLE on that edge.
  - din_en&&sync: abort the partial frame. Pulse frame_err for 1 cycle. Restart with the current bit as bit 0 (stay in RECV, count=1).
- Bit ordering:
  - MSB_FIRST=1: shift left with din entering the LSB, so the first bit ends in dout[WIDTH-1].
  - MSB_FIRST=0: shift right with din entering the MSB.
- Word completion, at edge E (last bit sampled):
  - If the holding register is free, or is being consumed at E (dout_valid&&dout_ready): dout is loaded at E and dout_valid=1 from the cycle after E.
  - Latency: last bit sampled to dout_valid high = 1 clock.
  - Otherwise (dout_valid=1 and dout_ready=0 at E): the new word is dropped, dout is unchanged, and overrun is set to 1.
- Handshake:
  - dout_valid&&dout_ready with no completion at the same edge: dout_valid goes to 0 and dout holds its last value.
  - dout must stay stable while dout_valid=1 and dout_ready=0.
  - dout_ready is ignored while dout_valid=0.
- busy=1 exactly while state=RECV.
- overrun clear/set conflict: clr_overrun=1 and a new overrun at the same edge leaves overrun=1 (set wins).
- A back-to-back frame may start on the edge right after completion.
  - Minimum word period is WIDTH enabled clocks; it is sustainable while dout_ready=1.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- Defined:
  - Each frame carries one extra even-parity bit after the WIDTH data bits, and completion occurs on that bit.
  - Adds state PARITY and output parity_err (1-bit, one-cycle pulse, reset 0).
  - Mismatch: the word is discarded (not loaded, overrun unaffected) and parity_err pulses.
  - sync during PARITY aborts the frame exactly as in RECV, with a frame_err pulse.
- Undefined:
  - No PARITY state and no parity_err port.
  - Frames are exactly WIDTH bits.

Test Plan:
- WIDTH=4, MSB_FIRST=1, dout_ready=1; send sync + bits 1,0,1,1 on consecutive cycles -> dout=4'b1011 and dout_valid=1 one clock after the 4th bit, then dout_valid=0 the next cycle.
- Same frame with din_en toggling 1,0,1,0,... -> dout=4'b1011; busy stays high across the gap cycles; no extra latency beyond 1 clock after the last enabled bit.
- dout_ready=0; send 4'hA then 4'h5 -> first word held with dout=4'hA; second word dropped; overrun=1. Then pulse clr_overrun -> overrun=0, dout still 4'hA.
- dout_ready=1; send 4'h3 and 4'hC back-to-back -> two dout_valid cycles carrying 4'h3 then 4'hC; overrun stays 0.
- Send sync + 2 bits, then sync + 1,1,0,0 -> frame_err pulses once; dout=4'b1100.
- Assert rst after 3 bits of a frame -> all outputs 0 and busy=0 next cycle; the following full frame 4'h9 is received correctly. With SERIAL_RX_PARITY_EN: frame 1011 + parity 0 -> parity_err pulses and no dout_valid.
